// File: rtl/retro_mem_arbiter.sv
// Round-robin burst arbiter sharing one memory port between NREQ requesters.
// Tracks outstanding read beats so a grant is held until its read data has returned.
module retro_mem_arbiter #(
  parameter int NREQ    = 3,
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 64,
  parameter int MAX_OUT = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NREQ-1:0]          ReqValid,
  output logic [NREQ-1:0]          ReqReady,
  input  logic [NREQ-1:0]          ReqWrite,
  input  logic [NREQ-1:0]          ReqLast,
  input  logic [NREQ*ADDR_W-1:0]   ReqAddr,
  input  logic [NREQ*DATA_W-1:0]   ReqWData,
  output logic [NREQ-1:0]          RspValid,
  output logic [DATA_W-1:0]        RspData,
  output logic                     MemValid,
  input  logic                     MemReady,
  output logic                     MemWrite,
  output logic [ADDR_W-1:0]        MemAddr,
  output logic [DATA_W-1:0]        MemWData,
  input  logic                     MemRspValid,
  input  logic [DATA_W-1:0]        MemRspData,
  output logic [NREQ-1:0]          Grant,
  output logic                     Busy
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SUM_W = IDX_W + 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]  gidx_q, gidx_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0]  out_q, out_d;

  logic [ADDR_W-1:0] addr_a  [NREQ];
  logic [DATA_W-1:0] wdata_a [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign addr_a[gi]  = ReqAddr[gi*ADDR_W +: ADDR_W];
      assign wdata_a[gi] = ReqWData[gi*DATA_W +: DATA_W];
    end
  endgenerate

  logic g_write, g_last, room, can_issue, in_burst, beat, rsp_ok, inc;

  assign g_write   = ReqWrite[gidx_q];
  assign g_last    = ReqLast[gidx_q];
  assign room      = out_q < CNT_W'(MAX_OUT);
  assign can_issue = g_write || room;
  assign in_burst  = (state_q == BURST) && !Reset;

  assign MemValid  = in_burst && ReqValid[gidx_q] && can_issue;
  assign MemWrite  = g_write;
  assign MemAddr   = addr_a[gidx_q];
  assign MemWData  = wdata_a[gidx_q];
  assign ReqReady  = (in_burst && MemReady && can_issue) ? grant_q : '0;

  assign beat      = MemValid && MemReady;
  assign inc       = beat && !g_write;
  // Responses with nothing outstanding are strays (e.g. after a reset) and are dropped.
  assign rsp_ok    = MemRspValid && (out_q != '0) && !Reset;
  assign RspValid  = rsp_ok ? grant_q : '0;
  assign RspData   = MemRspData;

  assign Grant     = grant_q;
  assign Busy      = (state_q != IDLE);

  always_comb begin
    out_d = out_q;
    case ({inc, rsp_ok})
      2'b10:   out_d = out_q + CNT_W'(1);
      2'b01:   out_d = out_q - CNT_W'(1);
      default: out_d = out_q;
    endcase
  end

  logic             rr_found;
  logic [IDX_W-1:0] rr_pick;
  logic [IDX_W-1:0] rr_cand;
  logic [SUM_W-1:0] rr_sum;

  // Search starts just after the previous owner so every requester gets a turn.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    rr_cand  = '0;
    rr_sum   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_sum = {1'b0, last_q} + SUM_W'(k);
      if (rr_sum >= SUM_W'(NREQ)) rr_sum = rr_sum - SUM_W'(NREQ);
      rr_cand = rr_sum[IDX_W-1:0];
      if (!rr_found && ReqValid[rr_cand]) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          grant_d          = '0;
          grant_d[rr_pick] = 1'b1;
          gidx_d           = rr_pick;
          state_d          = BURST;
        end
      end
      BURST: begin
        if (beat && g_last) begin
          if (out_d != '0) begin
            state_d = DRAIN;
          end else begin
            state_d = IDLE;
            last_d  = gidx_q;
            grant_d = '0;
          end
        end
      end
      DRAIN: begin
        if (out_d == '0) begin
          state_d = IDLE;
          last_d  = gidx_q;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IDX_W'(NREQ - 1);
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      out_q   <= out_d;
    end
  end

endmodule
